// File: rtl/i2c_pkg.sv
// Shared definitions for the single-byte I2C master: FSM state encoding and
// the four phase positions within one SCL bit.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    DATA     = 3'd4,
    DATA_ACK = 3'd5,
    STOP     = 3'd6,
    DONE     = 3'd7
  } i2c_state_e;

  localparam logic [1:0] PH_SET    = 2'd0;
  localparam logic [1:0] PH_RISE   = 2'd1;
  localparam logic [1:0] PH_SAMPLE = 2'd2;
  localparam logic [1:0] PH_FALL   = 2'd3;

  localparam logic [2:0] BIT_MSB = 3'd7;

endpackage

// File: rtl/i2c_edge_tick.sv
// Turns the divider output into a one-cycle tick on each of its edges;
// i2c_clk is treated as data in the ref_clk domain, never as a clock.
module i2c_edge_tick (
  input  logic ref_clk,
  input  logic reset,
  input  logic i2c_clk,
  output logic tick
);

  logic i2c_clk_q;

  always_ff @(posedge ref_clk) begin
    if (reset) i2c_clk_q <= 1'b0;
    else       i2c_clk_q <= i2c_clk;
  end

  assign tick = i2c_clk ^ i2c_clk_q;

endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// Each SCL bit spans four phase ticks taken from the divider edges.
//
//   state    | meaning
//   IDLE     | bus released, waiting for start
//   START    | SDA falls while SCL high, then SCL pulled low
//   ADDR     | shift out {addr,rw}, MSB first
//   ADDR_ACK | release SDA, sample slave ACK
//   DATA     | shift out wdata (write) or shift in rdata (read)
//   DATA_ACK | sample slave ACK (write) or master NACK (read)
//   STOP     | SDA rises while SCL high
//   DONE     | one-cycle done pulse
module i2c_byte_master
  import i2c_pkg::*;
(
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       i2c_clk,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       scl_pull,
  output logic       sda_pull,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [7:0] rdata
);

  logic       tick;
  i2c_state_e state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] addr_rw_q, addr_rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ack_error_q, ack_error_d;
  logic       scl_pull_q, scl_pull_d;
  logic       sda_pull_q, sda_pull_d;
  logic       rd_mode;

  i2c_edge_tick u_edge_tick (
    .ref_clk (ref_clk),
    .reset   (reset),
    .i2c_clk (i2c_clk),
    .tick    (tick)
  );

  assign rd_mode = addr_rw_q[0];

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= PH_SET;
      bit_cnt_q   <= BIT_MSB;
      addr_rw_q   <= 8'h00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      ack_error_q <= 1'b0;
      scl_pull_q  <= 1'b0;
      sda_pull_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_rw_q   <= addr_rw_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ack_error_q <= ack_error_d;
      scl_pull_q  <= scl_pull_d;
      sda_pull_q  <= sda_pull_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    addr_rw_d   = addr_rw_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack_error_d = ack_error_q;
    scl_pull_d  = scl_pull_q;
    sda_pull_d  = sda_pull_q;

    case (state_q)
      IDLE: begin
        scl_pull_d = 1'b0;
        sda_pull_d = 1'b0;
        if (start) begin
          addr_rw_d   = {addr, rw};
          wdata_d     = wdata;
          ack_error_d = 1'b0;
          phase_d     = PH_SET;
          state_d     = START;
        end
      end

      DONE: state_d = IDLE;

      default: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          // SCL rise/fall is common to every data-bit state; START/STOP override below
          if (phase_q == PH_RISE) scl_pull_d = 1'b0;
          if (phase_q == PH_FALL) scl_pull_d = 1'b1;

          case (state_q)
            START: begin
              case (phase_q)
                PH_SET:    begin scl_pull_d = 1'b0; sda_pull_d = 1'b0; end
                PH_RISE:   scl_pull_d = 1'b0;
                PH_SAMPLE: sda_pull_d = 1'b1;
                default: begin
                  bit_cnt_d = BIT_MSB;
                  state_d   = ADDR;
                end
              endcase
            end

            ADDR: begin
              if (phase_q == PH_SET) sda_pull_d = ~addr_rw_q[bit_cnt_q];
              if (phase_q == PH_FALL) begin
                if (bit_cnt_q == 3'd0) state_d = ADDR_ACK;
                else                   bit_cnt_d = bit_cnt_q - 3'd1;
              end
            end

            ADDR_ACK: begin
              if (phase_q == PH_SET)    sda_pull_d  = 1'b0;
              if (phase_q == PH_SAMPLE) ack_error_d = sda_in;
              if (phase_q == PH_FALL) begin
                bit_cnt_d = BIT_MSB;
                state_d   = ack_error_q ? STOP : DATA;
              end
            end

            DATA: begin
              if (phase_q == PH_SET) sda_pull_d = rd_mode ? 1'b0 : ~wdata_q[bit_cnt_q];
              if (phase_q == PH_SAMPLE && rd_mode) rdata_d = {rdata_q[6:0], sda_in};
              if (phase_q == PH_FALL) begin
                if (bit_cnt_q == 3'd0) state_d = DATA_ACK;
                else                   bit_cnt_d = bit_cnt_q - 3'd1;
              end
            end

            DATA_ACK: begin
              // read: releasing SDA here is the master NACK that ends the read
              if (phase_q == PH_SET) sda_pull_d = 1'b0;
              if (phase_q == PH_SAMPLE && !rd_mode) ack_error_d = ack_error_q | sda_in;
              if (phase_q == PH_FALL) state_d = STOP;
            end

            STOP: begin
              case (phase_q)
                PH_SET:    begin scl_pull_d = 1'b1; sda_pull_d = 1'b1; end
                PH_RISE:   scl_pull_d = 1'b0;
                PH_SAMPLE: sda_pull_d = 1'b0;
                default: begin
                  scl_pull_d = 1'b0;
                  state_d    = DONE;
                end
              endcase
            end

            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  assign scl_pull  = scl_pull_q;
  assign sda_pull  = sda_pull_q;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign ack_error = ack_error_q;
  assign rdata     = rdata_q;

endmodule
